vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//   Timing generator directly upstream of the frame-memory pixel generator.
//   - Divides the system clock into a pixel tick.
//   - Runs the horizontal and vertical counters.
//   - Drives the pixel coordinates and video_on that the pixel generator uses
//     to address its image memory, plus the hsync/vsync outputs for the VGA connector.
//   - Default timing is 640x480@60 (800x525 total).
// PARAMETERS
//   CLK_DIV    2    clk cycles per pixel (1 = every clk; 2 = 50MHz -> 25MHz)
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch, pixels
//   H_SYNC     96   hsync pulse width, pixels
//   H_BACK     48   horizontal back porch, pixels
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch, lines
//   V_SYNC     2    vsync pulse width, lines
//   V_BACK     33   vertical back porch, lines
// PORTS
//   clk          in   1   system clock; all logic rises on posedge
//   rst_n        in   1   asynchronous, active-low reset
//   en           in   1   1 = run; 0 = freeze divider and counters
//   p_tick       out  1   one-clk pulse per pixel period
//   pixel_x      out  10  current column, 0..H_TOTAL-1
//   pixel_y      out  10  current row, 0..V_TOTAL-1
//   video_on     out  1   1 when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
//   hsync        out  1   horizontal sync, active low
//   vsync        out  1   vertical sync, active low
//   frame_start  out  1   one-clk pulse when counters wrap to (0,0)
// BEHAVIOUR
//   - Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
//   - Reset values, while rst_n=0:
//     div_cnt=0, h_cnt=0, v_cnt=0, p_tick=0, pixel_x=0, pixel_y=0,
//     video_on=0, hsync=1, vsync=1, frame_start=0.
//   - Divider: div_cnt counts 0..CLK_DIV-1 and wraps, advancing only when en=1.
//     - p_tick is a registered output; it is 1 for exactly one clk when div_cnt
//       wraps to 0.
//     - With CLK_DIV=1, p_tick=1 on every clk with en=1.
//   - Counters advance only on a clk edge where en=1 and div_cnt==CLK_DIV-1
//     (the same edge that raises p_tick):
//     - h_cnt increments and wraps from H_TOTAL-1 to 0.
//     - On that wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
//   - Outputs are registered and decoded from the post-edge counter values.
//     They are therefore mutually consistent and glitch-free on every cycle:
//     - pixel_x=h_cnt; pixel_y=v_cnt.
//     - video_on = (h_cnt<H_DISPLAY) && (v_cnt<V_DISPLAY).
//     - hsync=0 iff H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC (656..751).
//     - vsync=0 iff V_DISPLAY+V_FRONT <= v_cnt < V_DISPLAY+V_FRONT+V_SYNC (490..491).
//   - First edge after rst_n rises: outputs decode (0,0), so video_on=1 and
//     hsync=vsync=1. frame_start stays 0 because no wrap has occurred.
//   - frame_start=1 for the single clk following the edge that moved
//     (H_TOTAL-1, V_TOTAL-1) to (0,0). It coincides with p_tick.
//   - en=0: all counters hold, p_tick and frame_start are 0, and the other
//     outputs hold their values. Resuming continues from the frozen phase
//     with no skipped or repeated pixel.
//   - rst_n asserted mid-line or mid-frame: every register goes to its reset
//     value immediately, without waiting for clk. The frame restarts from (0,0).
//   - Downstream stage registers its memory read one clk later. It uses
//     video_on to blank. This block adds no compensation delay.
//   - All parameters must satisfy H_TOTAL<=1024, V_TOTAL<=1024, CLK_DIV>=1.
// TESTING
//   T1 reset: hold rst_n=0 for 5 clk, then release with en=1
//      -> outputs at reset values while low; after the first edge
//         pixel_x=0, pixel_y=0, video_on=1.
//   T2 line timing, CLK_DIV=2
//      -> 800 p_tick between hsync falling edges; hsync low 96 ticks,
//         starting at pixel_x=656; video_on high 640 ticks per visible line.
//   T3 frame timing
//      -> vsync low only for pixel_y=490,491; frame_start period 840000 clk;
//         exactly 307200 video_on ticks per frame.
//   T4 wrap: run to (799,524)
//      -> next tick gives (0,0), frame_start=1 for 1 clk,
//         video_on=1, hsync=1, vsync=1.
//   T5 en=0 for 37 clk at pixel_x=100
//      -> no p_tick, outputs frozen; on resume the next tick gives pixel_x=101.
//   T6 rst_n pulse, asynchronous mid-clk, at (300,200)
//      -> outputs reset without a clk edge; frame restarts at (0,0);
//         CLK_DIV=1 variant gives p_tick every clk.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-clock divider, horizontal/vertical counters and
// registered coordinate, blanking and sync outputs for the frame-memory pixel path.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DIV_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;

  logic [DIV_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_tick;
  logic             w_h_wrap;
  logic             w_frame_wrap;
  logic             w_video_on;
  logic             w_hsync;
  logic             w_vsync;

  // Next-state counters; outputs decode these so they match the post-edge counts.
  always_comb begin
    w_tick       = en && (r_div_cnt == DIV_W'(CLK_DIV - 1));
    w_h_wrap     = w_tick && (r_h_cnt == CNT_W'(H_TOTAL - 1));
    w_frame_wrap = w_h_wrap && (r_v_cnt == CNT_W'(V_TOTAL - 1));

    w_div_nxt = r_div_cnt;
    if (en) begin
      w_div_nxt = w_tick ? '0 : r_div_cnt + DIV_W'(1);
    end

    w_h_nxt = r_h_cnt;
    if (w_tick) begin
      w_h_nxt = w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
    end

    w_v_nxt = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = w_frame_wrap ? '0 : r_v_cnt + CNT_W'(1);
    end
  end

  // Blanking and active-low sync windows.
  always_comb begin
    w_video_on = (32'(w_h_nxt) < H_DISPLAY) && (32'(w_v_nxt) < V_DISPLAY);
    w_hsync    = !((32'(w_h_nxt) >= HS_START) && (32'(w_h_nxt) < HS_END));
    w_vsync    = !((32'(w_v_nxt) >= VS_START) && (32'(w_v_nxt) < VS_END));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      p_tick      <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_nxt;
      r_h_cnt     <= w_h_nxt;
      r_v_cnt     <= w_v_nxt;
      p_tick      <= w_tick;
      pixel_x     <= w_h_nxt;
      pixel_y     <= w_v_nxt;
      video_on    <= w_video_on;
      hsync       <= w_hsync;
      vsync       <= w_vsync;
      frame_start <= w_frame_wrap;
    end
  end

endmodule
